// File: rtl/bool_sweep_ctrl.sv
// Sweeps a 4-input boolean block through all 16 vectors, samples y after a settle
// time, and scores the resulting truth table against an expected minterm mask.
module bool_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  input  logic        y_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] truth_table,
  output logic [4:0]  mismatch_count,
  output logic [3:0]  first_fail_idx
);

  localparam int unsigned VEC_W = 4;
  localparam int unsigned TT_W  = 16;
  localparam int unsigned MC_W  = 5;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_IDX    = VEC_W'(TT_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [VEC_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TT_W-1:0]   exp_q, exp_d;
  logic [TT_W-1:0]   tt_q, tt_d;
  logic [MC_W-1:0]   mc_q, mc_d;
  logic [VEC_W-1:0]  ffi_q, ffi_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              miss_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    tt_d    = tt_q;
    mc_d    = mc_q;
    ffi_d   = ffi_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    miss_c  = (y_in != exp_q[idx_q]);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          exp_d   = expected;
          idx_d   = '0;
          tt_d    = '0;
          mc_d    = '0;
          ffi_d   = '0;
          pass_d  = 1'b0;
          cnt_d   = SETTLE_LOAD;
          busy_d  = 1'b1;
          vec_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          vec_d   = '0;
          pass_d  = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          tt_d[idx_q] = y_in;
          if (miss_c) begin
            mc_d = mc_q + MC_W'(1);
            if (mc_q == '0) ffi_d = idx_q;
          end
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + VEC_W'(1);
            vec_d = idx_q + VEC_W'(1);
            cnt_d = SETTLE_LOAD;
          end else begin
            state_d = FIN;
            busy_d  = 1'b0;
            vec_d   = '0;
            done_d  = 1'b1;
            pass_d  = (mc_d == '0);
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      exp_q  <= '0;
      tt_q   <= '0;
      mc_q   <= '0;
      ffi_q  <= '0;
      vec_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      exp_q  <= exp_d;
      tt_q   <= tt_d;
      mc_q   <= mc_d;
      ffi_q  <= ffi_d;
      vec_q  <= vec_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end

  assign a              = vec_q[3];
  assign b              = vec_q[2];
  assign c              = vec_q[1];
  assign d              = vec_q[0];
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign truth_table    = tt_q;
  assign mismatch_count = mc_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_bool_sweep_ctrl.sv
// Bench for bool_sweep_ctrl: two instances (settle 2 and settle 1) driven by
// table vectors, random vectors scored by a truth-table model, and corner sequences.
module tb_bool_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] expected;
  logic [15:0] ytt;
  logic        start1, abort1, start2, abort2;
  logic        a1, b1, c1, d1, busy1, done1, pass1;
  logic        a2, b2, c2, d2, busy2, done2, pass2;
  logic [15:0] tt1, tt2;
  logic [4:0]  mc1, mc2;
  logic [3:0]  ffi1, ffi2;
  logic        y1, y2;

  int n_cmp  = 0;
  int n_fail = 0;
  int cur    = 0;

  always #5 clk = ~clk;

  // Boolean block under test: a lookup of the vector currently driven
  assign y1 = ytt[{a1, b1, c1, d1}];
  assign y2 = ytt[{a2, b2, c2, d2}];

  bool_sweep_ctrl #(.SETTLE_CYCLES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .expected(expected),
    .y_in(y1), .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
    .pass(pass1), .truth_table(tt1), .mismatch_count(mc1), .first_fail_idx(ffi1));

  bool_sweep_ctrl #(.SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .expected(expected),
    .y_in(y2), .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2),
    .pass(pass2), .truth_table(tt2), .mismatch_count(mc2), .first_fail_idx(ffi2));

  logic [3:0]  o_vec;
  logic        o_busy, o_done, o_pass;
  logic [15:0] o_tt;
  logic [4:0]  o_mc;
  logic [3:0]  o_ffi;

  always_comb begin
    if (cur == 1) begin
      o_vec = {a2, b2, c2, d2}; o_busy = busy2; o_done = done2; o_pass = pass2;
      o_tt = tt2; o_mc = mc2; o_ffi = ffi2;
    end else begin
      o_vec = {a1, b1, c1, d1}; o_busy = busy1; o_done = done1; o_pass = pass1;
      o_tt = tt1; o_mc = mc1; o_ffi = ffi1;
    end
  end

  typedef struct {
    logic [15:0] e;
    logic [15:0] yt;
    logic [15:0] tt;
    logic [4:0]  mc;
    logic [3:0]  ffi;
    logic        ps;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s (dut%0d @%0t): got 0x%0h required 0x%0h", name, cur + 1, $time, act, req);
    end
  endtask

  // Scores the first n vectors: what was sampled, how many differ, lowest differing index
  function automatic void model(input logic [15:0] e, input logic [15:0] yt, input int n,
                                output logic [15:0] tt, output logic [4:0] mc,
                                output logic [3:0] ffi);
    int cnt = 0;
    int first = 0;
    tt = '0;
    for (int i = 0; i < n; i++) begin
      tt[i] = yt[i];
      if (yt[i] != e[i]) begin
        if (cnt == 0) first = i;
        cnt++;
      end
    end
    mc  = 5'(cnt);
    ffi = 4'(first);
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 1) start2 = v; else start1 = v;
  endtask

  task automatic set_abort(input int sel, input logic v);
    if (sel == 1) abort2 = v; else abort1 = v;
  endtask

  task automatic chk_results(input string tag, input logic [15:0] tt, input logic [4:0] mc,
                             input logic [3:0] ffi, input logic ps);
    chk({tag, "_tt"}, int'(o_tt), int'(tt));
    chk({tag, "_mc"}, int'(o_mc), int'(mc));
    chk({tag, "_pass"}, int'(o_pass), int'(ps));
    if (!ps) chk({tag, "_ffi"}, int'(o_ffi), int'(ffi));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vec"}, int'(o_vec), 0);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_done"}, int'(o_done), 0);
    chk({tag, "_pass"}, int'(o_pass), 0);
    chk({tag, "_tt"}, int'(o_tt), 0);
    chk({tag, "_mc"}, int'(o_mc), 0);
    chk({tag, "_ffi"}, int'(o_ffi), 0);
  endtask

  // mode: 0 plain, 1 start re-pulse + expected change mid-sweep,
  //       2 abort at vector 7, 3 async reset at vector 9, 4 start with abort in IDLE
  task automatic sweep(input int sel, input logic [15:0] e, input logic [15:0] yt,
                       input logic [15:0] rtt, input logic [4:0] rmc,
                       input logic [3:0] rffi, input logic rps, input int mode);
    int s = (sel == 1) ? 1 : 2;
    int n = 16 * s;
    logic [15:0] ptt;
    logic [4:0]  pmc;
    logic [3:0]  pffi;
    cur = sel;
    ytt = yt;
    expected = e;
    @(negedge clk);
    set_start(sel, 1'b1);
    if (mode == 4) set_abort(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    set_abort(sel, 1'b0);
    for (int k = 0; k < n; k++) begin
      chk("run_busy", int'(o_busy), 1);
      chk("run_vec", int'(o_vec), k / s);
      chk("run_done", int'(o_done), 0);
      if (mode == 1 && k == 10) begin
        set_start(sel, 1'b1);
        expected = ~e;
      end
      if (mode == 1 && k == 12) set_start(sel, 1'b0);
      if (mode == 2 && k == 7 * s) begin
        set_abort(sel, 1'b1);
        @(negedge clk);
        set_abort(sel, 1'b0);
        model(e, yt, 7, ptt, pmc, pffi);
        chk("abort_busy", int'(o_busy), 0);
        chk("abort_vec", int'(o_vec), 0);
        chk("abort_done", int'(o_done), 0);
        chk("abort_tt", int'(o_tt), int'(ptt));
        chk("abort_mc", int'(o_mc), int'(pmc));
        chk("abort_ffi", int'(o_ffi), int'(pffi));
        chk("abort_pass", int'(o_pass), 0);
        for (int j = 0; j < 3 * s * 16; j++) begin
          @(negedge clk);
          chk("abort_nodone", int'(o_done), 0);
        end
        chk("abort_hold_tt", int'(o_tt), int'(ptt));
        return;
      end
      if (mode == 3 && k == 9 * s) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_mid");
        @(negedge clk);
        chk("rst_nodone", int'(o_done), 0);
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
    end
    expected = e;
    chk("fin_done", int'(o_done), 1);
    chk("fin_busy", int'(o_busy), 0);
    chk("fin_vec", int'(o_vec), 0);
    chk_results("fin", rtt, rmc, rffi, rps);
    // start high during FIN is ignored; abort in IDLE has no effect
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    set_abort(sel, 1'b1);
    chk("post_done", int'(o_done), 0);
    chk("post_busy", int'(o_busy), 0);
    @(negedge clk);
    set_abort(sel, 1'b0);
    @(negedge clk);
    chk("hold_busy", int'(o_busy), 0);
    chk_results("hold", rtt, rmc, rffi, rps);
  endtask

  initial begin
    logic [15:0] e, yt, rtt;
    logic [4:0]  rmc;
    logic [3:0]  rffi;

    tbl[0] = '{e: 16'h6996, yt: 16'h6996, tt: 16'h6996, mc: 5'd0,  ffi: 4'd0,  ps: 1'b1};
    tbl[1] = '{e: 16'h8001, yt: 16'h0000, tt: 16'h0000, mc: 5'd2,  ffi: 4'd0,  ps: 1'b0};
    tbl[2] = '{e: 16'hF0F0, yt: 16'hF8D0, tt: 16'hF8D0, mc: 5'd2,  ffi: 4'd5,  ps: 1'b0};
    tbl[3] = '{e: 16'hFFFF, yt: 16'h0000, tt: 16'h0000, mc: 5'd16, ffi: 4'd0,  ps: 1'b0};
    tbl[4] = '{e: 16'h0000, yt: 16'h8000, tt: 16'h8000, mc: 5'd1,  ffi: 4'd15, ps: 1'b0};

    rst_n = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; start2 = 1'b0; abort2 = 1'b0;
    expected = 16'h0; ytt = 16'h0;
    #12;
    cur = 0; chk_zero("reset");
    cur = 1; chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) sweep(i % 2, tbl[i].e, tbl[i].yt, tbl[i].tt,
                                      tbl[i].mc, tbl[i].ffi, tbl[i].ps, 0);

    for (int r = 0; r < 8; r++) begin
      e  = 16'($urandom);
      yt = e ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      model(e, yt, 16, rtt, rmc, rffi);
      sweep(r % 2, e, yt, rtt, rmc, rffi, (rmc == 5'd0), (r == 3) ? 4 : 0);
    end

    // mid-sweep start and expected change must not disturb the result
    sweep(0, tbl[2].e, tbl[2].yt, tbl[2].tt, tbl[2].mc, tbl[2].ffi, tbl[2].ps, 1);
    sweep(1, tbl[0].e, tbl[0].yt, tbl[0].tt, tbl[0].mc, tbl[0].ffi, tbl[0].ps, 1);

    // abort at vector 7 leaves bits 7..15 clear
    sweep(0, tbl[2].e, tbl[2].yt, 16'h0, 5'd0, 4'd0, 1'b0, 2);
    sweep(1, 16'hFFFF, 16'h0000, 16'h0, 5'd0, 4'd0, 1'b0, 2);

    // async reset mid-sweep, then a fresh full sweep on each instance
    sweep(0, tbl[0].e, tbl[0].yt, 16'h0, 5'd0, 4'd0, 1'b0, 3);
    sweep(0, tbl[0].e, tbl[0].yt, tbl[0].tt, tbl[0].mc, tbl[0].ffi, tbl[0].ps, 0);
    sweep(1, tbl[1].e, tbl[1].yt, 16'h0, 5'd0, 4'd0, 1'b0, 3);
    sweep(1, tbl[0].e, tbl[0].yt, tbl[0].tt, tbl[0].mc, tbl[0].ffi, tbl[0].ps, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
